data_ram_arbiter: RTL

- Shares the single data RAM between the CPU data port and a host/debug port.
- Host transactions are bursts of 1..MAX_BURST words with auto-incrementing addresses.
- While the host owns the RAM, the CPU is frozen by gating its enable, so PC, registers and CPSR hold.
- A fairness quantum guarantees the CPU forward progress between host bursts.
- Sits between the CPU data pins, the top-level run control and the RAM.

---
 rtl/data_ram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - data RAM arbiter between CPU data port and host burst port
//
// Purpose:
//   Shares the single data RAM between the CPU data port and a host/debug
//   port. While the host owns the RAM the CPU is frozen through cpu_enable_o.
//   A quantum counter guarantees the CPU CPU_QUANTUM run cycles between
//   consecutive host bursts.
//
// Ports:
//   clk_i, res_ni        clock (rising edge), asynchronous active-low reset
//   run_i, cpu_enable_o  top-level run request in, CPU enable out
//   cpu_*_i, cpu_rdata_o CPU data port (sel, ld, addr, wdata, clr / read data)
//   host_req_i .. host_wdata_i   host burst request (level, held until ack)
//   host_ack_o, host_beat_o, host_rdata_o, host_rvalid_o, host_done_o
//                        host handshake, beat strobe and registered read data
//   ram_*_o, ram_rdata_i RAM pins
module data_ram_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 5,
  parameter int CPU_QUANTUM = 4
) (
  input  logic              clk_i,
  input  logic              res_ni,
  input  logic              run_i,
  output logic              cpu_enable_o,
  input  logic              cpu_sel_i,
  input  logic              cpu_ld_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_clr_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_wr_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [LEN_W-1:0]  host_len_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic              host_beat_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,
  output logic              host_done_o,
  output logic              ram_sel_o,
  output logic              ram_ld_o,
  output logic              ram_clr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int QW = $clog2(CPU_QUANTUM + 1);
  localparam logic [QW-1:0]    Q_MAX   = QW'(CPU_QUANTUM);
  localparam logic [QW-1:0]    Q_ONE   = QW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    CPU_OWN    = 2'd0,
    HOST_GRANT = 2'd1,
    HOST_BURST = 2'd2
  } state_e;

  state_e              state_q;
  logic [QW-1:0]       quantum_q;
  logic [QW-1:0]       quantum_d;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic                wr_q;
  logic [LEN_W-1:0]    beat_q;
  logic [DATA_W-1:0]   host_rdata_q;
  logic                host_rvalid_q;
  logic                host_done_q;
  logic                grant_go;
  logic                last_beat;

  // The current run cycle already counts toward the quantum, so the CPU
  // gets exactly CPU_QUANTUM enabled cycles before the host is granted.
  always_comb begin
    quantum_d = quantum_q;
    if (run_i && (quantum_q != Q_MAX)) begin
      quantum_d = quantum_q + Q_ONE;
    end
  end

  assign grant_go  = host_req_i && ((quantum_d == Q_MAX) || !run_i);
  assign last_beat = (beat_q == (len_q - LEN_ONE));

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state_q       <= CPU_OWN;
      // Reset counts as a completed quantum: the host is eligible at once.
      quantum_q     <= Q_MAX;
      base_q        <= '0;
      len_q         <= LEN_ONE;
      wr_q          <= 1'b0;
      beat_q        <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_done_q   <= 1'b0;
    end else begin
      host_rvalid_q <= 1'b0;
      host_done_q   <= 1'b0;
      case (state_q)
        CPU_OWN: begin
          quantum_q <= quantum_d;
          if (grant_go) begin
            state_q <= HOST_GRANT;
          end
        end
        HOST_GRANT: begin
          base_q  <= host_addr_i;
          len_q   <= (host_len_i == '0) ? LEN_ONE : host_len_i;
          wr_q    <= host_wr_i;
          beat_q  <= '0;
          state_q <= HOST_BURST;
        end
        HOST_BURST: begin
          if (!wr_q) begin
            host_rdata_q  <= ram_rdata_i;
            host_rvalid_q <= 1'b1;
          end
          beat_q <= beat_q + LEN_ONE;
          if (last_beat) begin
            host_done_q <= 1'b1;
            quantum_q   <= '0;
            state_q     <= CPU_OWN;
          end
        end
        default: begin
          state_q <= CPU_OWN;
        end
      endcase
    end
  end

  // Pin muxing is decoded from the registered state; the CPU path is a
  // combinational pass-through. Everything is forced quiet while in reset.
  always_comb begin
    cpu_enable_o = 1'b0;
    cpu_rdata_o  = '0;
    host_ack_o   = 1'b0;
    host_beat_o  = 1'b0;
    ram_sel_o    = 1'b0;
    ram_ld_o     = 1'b0;
    ram_addr_o   = '0;
    ram_wdata_o  = '0;
    if (res_ni) begin
      case (state_q)
        CPU_OWN: begin
          cpu_enable_o = run_i;
          cpu_rdata_o  = ram_rdata_i;
          ram_sel_o    = cpu_sel_i;
          ram_ld_o     = cpu_ld_i;
          ram_addr_o   = cpu_addr_i;
          ram_wdata_o  = cpu_wdata_i;
        end
        HOST_GRANT: begin
          host_ack_o = 1'b1;
        end
        HOST_BURST: begin
          host_beat_o = 1'b1;
          ram_sel_o   = 1'b1;
          ram_ld_o    = ~wr_q;
          // Natural ADDR_W-bit wrap from the top of memory back to 0.
          ram_addr_o  = base_q + ADDR_W'(beat_q);
          ram_wdata_o = host_wdata_i;
        end
        default: begin
          cpu_enable_o = 1'b0;
        end
      endcase
    end
  end

  assign ram_clr_o     = cpu_clr_i;
  assign host_rdata_o  = host_rdata_q;
  assign host_rvalid_o = host_rvalid_q;
  assign host_done_o   = host_done_q;

endmodule
